// File: rtl/countdown_controller_pkg.sv
// Shared encodings and default countdown lengths for the mode-select path
// (button decoder, countdown controller, display logic).
package countdown_controller_pkg;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_1    = 2'b01;
  localparam logic [1:0] MODE_2    = 2'b10;
  localparam logic [1:0] MODE_3    = 2'b11;

  localparam int DEF_MODE1_SECS = 30;
  localparam int DEF_MODE2_SECS = 60;
  localparam int DEF_MODE3_SECS = 90;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } cd_state_e;

endpackage

// File: rtl/countdown_controller_if.sv
// Mode-select link: the decoder (master) requests a run, the controller (slave)
// reports remaining seconds, activity, completion and the latched mode.
interface countdown_controller_if #(
  parameter int SECS_W = 7
);
  logic              countdown_start_i;
  logic [1:0]        mode_i;
  logic [SECS_W-1:0] secs_o;
  logic              active_o;
  logic              done_o;
  logic [1:0]        mode_o;

  modport master (
    output countdown_start_i, mode_i,
    input  secs_o, active_o, done_o, mode_o
  );

  modport slave (
    input  countdown_start_i, mode_i,
    output secs_o, active_o, done_o, mode_o
  );
endinterface

// File: rtl/countdown_controller_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICKS_PER_SEC enabled
// cycles; clear restarts the period so the first tick lands a full period later.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Period counter, wrapping at LAST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt <= {CNT_W{1'b0}};
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt <= {CNT_W{1'b0}};
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/countdown_controller.sv
// Per-mode seconds countdown: starts on a rising start level with a non-menu
// mode, counts down once per prescaler tick, pulses done at zero.
module countdown_controller
  import countdown_controller_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int MODE1_SECS    = DEF_MODE1_SECS,
  parameter int MODE2_SECS    = DEF_MODE2_SECS,
  parameter int MODE3_SECS    = DEF_MODE3_SECS,
  parameter int SECS_W        = 7
) (
  input logic                   clk_i,
  input logic                   rst_i,
  countdown_controller_if.slave cd
);

  cd_state_e         state_q, state_d;
  logic              start_q;
  logic              start_rise;
  logic              tick;
  logic              presc_clear;
  logic              presc_enable;
  logic [SECS_W-1:0] secs_q, secs_d;
  logic [1:0]        mode_q, mode_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  function automatic logic [SECS_W-1:0] secs_for_mode(input logic [1:0] m);
    case (m)
      MODE_1:  return SECS_W'(MODE1_SECS);
      MODE_2:  return SECS_W'(MODE2_SECS);
      MODE_3:  return SECS_W'(MODE3_SECS);
      default: return {SECS_W{1'b0}};
    endcase
  endfunction

  assign start_rise   = cd.countdown_start_i & ~start_q;
  assign presc_enable = (state_q == ST_COUNT);

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (presc_clear),
    .enable (presc_enable),
    .tick   (tick)
  );

  // State register and start-level history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= cd.countdown_start_i;
    end
  end

  // Next state and next output values; a low start level always wins over a tick.
  always_comb begin
    state_d     = state_q;
    secs_d      = secs_q;
    mode_d      = mode_q;
    active_d    = active_q;
    done_d      = 1'b0;
    presc_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise && (cd.mode_i != MODE_NONE)) begin
          state_d     = ST_COUNT;
          mode_d      = cd.mode_i;
          secs_d      = secs_for_mode(cd.mode_i);
          active_d    = 1'b1;
          presc_clear = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!cd.countdown_start_i) begin
          state_d  = ST_IDLE;
          secs_d   = {SECS_W{1'b0}};
          mode_d   = MODE_NONE;
          active_d = 1'b0;
        end else if (tick) begin
          if (secs_q > SECS_W'(1)) begin
            secs_d = secs_q - SECS_W'(1);
          end else begin
            secs_d   = {SECS_W{1'b0}};
            done_d   = 1'b1;
            active_d = 1'b0;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_DONE: begin
        if (!cd.countdown_start_i) begin
          state_d  = ST_IDLE;
          secs_d   = {SECS_W{1'b0}};
          mode_d   = MODE_NONE;
          active_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        secs_d   = {SECS_W{1'b0}};
        mode_d   = MODE_NONE;
        active_d = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      secs_q   <= {SECS_W{1'b0}};
      mode_q   <= MODE_NONE;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      secs_q   <= secs_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign cd.secs_o   = secs_q;
  assign cd.mode_o   = mode_q;
  assign cd.active_o = active_q;
  assign cd.done_o   = done_q;

endmodule

// File: tb/tb_countdown_controller.sv
// Bench for countdown_controller: expected outputs come from the countdown rule
// secs = N - floor(k / TICKS) for k cycles after load, done at k = N * TICKS.
module tb_countdown_controller;

  localparam int T  = 4;
  localparam int M1 = 3;
  localparam int M2 = 5;
  localparam int M3 = 7;
  localparam int SW = 7;
  localparam logic [SW+3:0] IDLE_VEC = {SW'(0), 1'b0, 1'b0, 2'b00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  countdown_controller_if #(.SECS_W(SW)) cd ();

  countdown_controller #(
    .TICKS_PER_SEC(T),
    .MODE1_SECS   (M1),
    .MODE2_SECS   (M2),
    .MODE3_SECS   (M3),
    .SECS_W       (SW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cd   (cd)
  );

  function automatic int secs_of(input logic [1:0] m);
    case (m)
      2'b01:   return M1;
      2'b10:   return M2;
      2'b11:   return M3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [SW+3:0] observed();
    return {cd.secs_o, cd.active_o, cd.done_o, cd.mode_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One run of mode m; abort_k >= 0 drops start after observing cycle abort_k.
  task automatic run_count(input string name, input logic [1:0] m, input int abort_k,
                           input bit toggle_mode);
    int n = secs_of(m);
    int total = n * T;
    logic [SW+3:0] exp;
    cd.mode_i = m;
    cd.countdown_start_i = 1'b1;
    step();
    for (int k = 0; k <= total + 2; k++) begin
      if (k < total) exp = {SW'(n - k / T), 1'b1, 1'b0, m};
      else if (k == total) exp = {SW'(0), 1'b0, 1'b1, m};
      else exp = {SW'(0), 1'b0, 1'b0, m};
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL %s k=%0d {secs,act,done,mode} got %h expected %h", name, k, observed(), exp);
      end
      if (k == abort_k) begin
        cd.countdown_start_i = 1'b0;
        step();
        checks++;
        if (observed() !== IDLE_VEC) begin
          errors++;
          $display("FAIL %s_abort k=%0d got %h expected %h", name, k, observed(), IDLE_VEC);
        end
        return;
      end
      if (toggle_mode) cd.mode_i = 2'($urandom_range(0, 3));
      step();
    end
    cd.countdown_start_i = 1'b0;
    step();
    checks++;
    if (observed() !== IDLE_VEC) begin
      errors++;
      $display("FAIL %s_return got %h expected %h", name, observed(), IDLE_VEC);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cd.countdown_start_i = 1'b0;
    cd.mode_i = 2'b00;
    repeat (3) step();
    checks++;
    if (observed() !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset got %h expected %h", observed(), IDLE_VEC);
    end
    rst = 1'b0;
    step();
    checks++;
    if (observed() !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset_release got %h expected %h", observed(), IDLE_VEC);
    end
  endtask

  task automatic test_modes();
    run_count("mode1", 2'b01, -1, 1'b0);
    run_count("mode2", 2'b10, -1, 1'b0);
    run_count("mode3", 2'b11, -1, 1'b0);
  endtask

  task automatic test_mode_none();
    cd.mode_i = 2'b00;
    cd.countdown_start_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (observed() !== IDLE_VEC) begin
        errors++;
        $display("FAIL mode_none cyc=%0d got %h expected %h", i, observed(), IDLE_VEC);
      end
    end
    cd.countdown_start_i = 1'b0;
    step();
  endtask

  task automatic test_abort_on_tick();
    // k = 2*T-1 is the last cycle at secs=2, so the tick coincides with the drop.
    run_count("abort_tick", 2'b01, 2 * T - 1, 1'b0);
    run_count("restart", 2'b01, -1, 1'b0);
  endtask

  task automatic test_mode_toggle();
    run_count("toggle", 2'b01, -1, 1'b1);
  endtask

  task automatic test_reset_midcount();
    logic [SW+3:0] exp;
    cd.mode_i = 2'b10;
    cd.countdown_start_i = 1'b1;
    step();
    repeat (6) step();
    exp = {SW'(M2 - 6 / T), 1'b1, 1'b0, 2'b10};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL pre_reset got %h expected %h", observed(), exp);
    end
    rst = 1'b1;
    step();
    checks++;
    if (observed() !== IDLE_VEC) begin
      errors++;
      $display("FAIL mid_reset got %h expected %h", observed(), IDLE_VEC);
    end
    rst = 1'b0;
    cd.countdown_start_i = 1'b0;
    step();
    checks++;
    if (observed() !== IDLE_VEC) begin
      errors++;
      $display("FAIL post_reset got %h expected %h", observed(), IDLE_VEC);
    end
    run_count("after_reset", 2'b10, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      logic [1:0] m = 2'($urandom_range(1, 3));
      int abort_k = -1;
      int gap = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) abort_k = $urandom_range(0, secs_of(m) * T - 1);
      cd.mode_i = 2'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        checks++;
        if (observed() !== IDLE_VEC) begin
          errors++;
          $display("FAIL random_gap r=%0d got %h expected %h", r, observed(), IDLE_VEC);
        end
      end
      run_count("random", m, abort_k, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    cd.countdown_start_i = 1'b0;
    cd.mode_i = 2'b00;
    test_reset();
    test_modes();
    test_mode_none();
    test_abort_on_tick();
    test_mode_toggle();
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
